// File: rtl/softmax_avg_argmax_if.sv
// Intermediate-result memory port used by the softmax averaging stage.
// The stage drives the master side; the memory answers reads one cycle later.
interface softmax_avg_argmax_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/softmax_avg_argmax.sv
// Averages the current softmax vector with up to two previous ones, writes the
// average back, picks the argmax as sleep stage and shifts the history window.
module softmax_avg_argmax #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned CUR_BASE   = 32,
  parameter int unsigned PREV_BASE  = 57334,
  parameter int unsigned AVG_BASE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           sleep_stage,
  softmax_avg_argmax_if.master mem
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned COMP_W = 48;
  localparam int unsigned Q_COMP = 21;
  localparam int unsigned N_RD   = 3 * NUM_STAGES;
  localparam int unsigned N_RET  = 2 * NUM_STAGES;
  localparam int unsigned CNT_W  = $clog2(N_RD + 1);
  localparam int unsigned IDX_W  = $clog2(NUM_STAGES);

  localparam logic signed [COMP_W-1:0] RECIP_1 = COMP_W'(2097152);
  localparam logic signed [COMP_W-1:0] RECIP_2 = COMP_W'(1048576);
  localparam logic signed [COMP_W-1:0] RECIP_3 = COMP_W'(699051);
  localparam logic signed [COMP_W-1:0] ROUND_C = COMP_W'(1) <<< (Q_COMP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_AVG, S_RETIRE, S_DONE
  } state_t;

  typedef logic signed [DATA_W-1:0] word_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         nvalid_q, nvalid_d;
  word_t              cur_q [NUM_STAGES];
  word_t              cur_d [NUM_STAGES];
  word_t              p1_q  [NUM_STAGES];
  word_t              p1_d  [NUM_STAGES];
  word_t              p2_q  [NUM_STAGES];
  word_t              p2_d  [NUM_STAGES];
  logic [2:0]         best_idx_q, best_idx_d;
  word_t              best_val_q, best_val_d;
  logic [2:0]         sleep_stage_q, sleep_stage_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  word_t              wr_data_q, wr_data_d;

  // Rounded average of three same-format operands for 1..3 valid entries.
  function automatic word_t avg_of(input word_t a, input word_t b, input word_t c,
                                   input logic [1:0] nv);
    logic signed [COMP_W-1:0] sum;
    logic signed [COMP_W-1:0] recip;
    logic signed [COMP_W-1:0] prod;
    sum = COMP_W'(a) + COMP_W'(b) + COMP_W'(c);
    case (nv)
      2'd0:    recip = RECIP_1;
      2'd1:    recip = RECIP_2;
      default: recip = RECIP_3;
    endcase
    prod = sum * recip + ROUND_C;
    return DATA_W'(prod >>> Q_COMP);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      nvalid_q      <= '0;
      best_idx_q    <= '0;
      best_val_q    <= '0;
      sleep_stage_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        cur_q[i] <= '0;
        p1_q[i]  <= '0;
        p2_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      nvalid_q      <= nvalid_d;
      best_idx_q    <= best_idx_d;
      best_val_q    <= best_val_d;
      sleep_stage_q <= sleep_stage_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        cur_q[i] <= cur_d[i];
        p1_q[i]  <= p1_d[i];
        p2_q[i]  <= p2_d[i];
      end
    end
  end

  logic [CNT_W-1:0] slot;
  logic [IDX_W-1:0] oidx;
  word_t            avg_c;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    nvalid_d      = nvalid_q;
    best_idx_d    = best_idx_q;
    best_val_d    = best_val_q;
    sleep_stage_d = sleep_stage_q;
    cur_d         = cur_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    rd_en_d       = 1'b0;
    rd_addr_d     = '0;
    wr_en_d       = 1'b0;
    wr_addr_d     = '0;
    wr_data_d     = '0;
    slot          = cnt_q - CNT_W'(1);
    oidx          = '0;
    avg_c         = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        // Read data lags the request by one cycle, so slot = cnt - 1.
        if (cnt_q != '0) begin
          if (slot < CNT_W'(NUM_STAGES)) begin
            cur_d[IDX_W'(slot)] = word_t'(mem.rd_data);
          end else if (slot < CNT_W'(N_RET)) begin
            p1_d[IDX_W'(slot - CNT_W'(NUM_STAGES))] =
              (nvalid_q >= 2'd1) ? word_t'(mem.rd_data) : '0;
          end else begin
            p2_d[IDX_W'(slot - CNT_W'(N_RET))] =
              (nvalid_q >= 2'd2) ? word_t'(mem.rd_data) : '0;
          end
        end
        if (cnt_q == CNT_W'(N_RD)) begin
          state_d = S_AVG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_AVG: begin
        if (cnt_q == CNT_W'(NUM_STAGES - 1)) begin
          state_d = S_RETIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RETIRE: begin
        if (cnt_q == CNT_W'(N_RET - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        nvalid_d = (nvalid_q == 2'd2) ? 2'd2 : nvalid_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are derived from the state being entered.
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_READ: begin
        if (cnt_d < CNT_W'(N_RD)) begin
          rd_en_d = 1'b1;
          if (cnt_d < CNT_W'(NUM_STAGES))
            rd_addr_d = ADDR_W'(CUR_BASE + 32'(cnt_d));
          else
            rd_addr_d = ADDR_W'(PREV_BASE + 32'(cnt_d) - NUM_STAGES);
        end
      end
      S_AVG: begin
        oidx      = IDX_W'(cnt_d);
        avg_c     = avg_of(cur_q[oidx], p1_q[oidx], p2_q[oidx], nvalid_q);
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(AVG_BASE + 32'(cnt_d));
        wr_data_d = avg_c;
        // Strict compare keeps the lowest index on ties.
        if (cnt_d == '0 || avg_c > best_val_q) begin
          best_idx_d = 3'(cnt_d);
          best_val_d = avg_c;
        end
      end
      S_RETIRE: begin
        wr_en_d = 1'b1;
        if (cnt_d < CNT_W'(NUM_STAGES)) begin
          oidx      = IDX_W'(cnt_d);
          wr_addr_d = ADDR_W'(PREV_BASE + NUM_STAGES + 32'(cnt_d));
          wr_data_d = p1_q[oidx];
        end else begin
          oidx      = IDX_W'(cnt_d - CNT_W'(NUM_STAGES));
          wr_addr_d = ADDR_W'(PREV_BASE + 32'(cnt_d) - NUM_STAGES);
          wr_data_d = cur_q[oidx];
        end
      end
      S_DONE: begin
        done_d        = 1'b1;
        sleep_stage_d = best_idx_q;
      end
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sleep_stage = sleep_stage_q;
  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = rd_addr_q;
  assign mem.wr_en   = wr_en_q;
  assign mem.wr_addr = wr_addr_q;
  assign mem.wr_data = wr_data_q;

endmodule
